// File: rtl/keccak_padder.sv
// Byte-stream to rate-block transmitter for keccak_buffer.
// Applies Keccak pad10*1 and sequences the block handoff.
module keccak_padder #(
  parameter int IN_BUF_SIZE = 64,
  localparam int WORDS_PER_BLOCK = 1024 / IN_BUF_SIZE,
  localparam int BYTES_PER_WORD = IN_BUF_SIZE / 8,
  localparam int CW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1,
  localparam int BW = $clog2(BYTES_PER_WORD + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [IN_BUF_SIZE-1:0] Msg_in,
  input  logic                   Msg_in_valid,
  input  logic                   Msg_in_last,
  input  logic [BW-1:0]          Msg_in_bytes,
  output logic                   Msg_in_ready,
  output logic [IN_BUF_SIZE-1:0] Din_buffer_in,
  output logic                   Din_buffer_in_valid,
  input  logic                   Din_buffer_full,
  input  logic                   Ready,
  output logic                   Last_block,
  input  logic                   Dout_buffer_out_valid,
  output logic                   Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSG,
    S_PAD,
    S_LAST,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic            pad_first_q, pad_first_d;
  logic            dout_seen_q, dout_seen_d;

  logic                   blk_end;
  logic [CW-1:0]          cnt_next;
  logic                   short_last;
  logic [IN_BUF_SIZE-1:0] msg_word;
  logic [IN_BUF_SIZE-1:0] pad_word;
  logic                   msg_ready;
  logic                   out_valid;
  logic [IN_BUF_SIZE-1:0] out_word;

  assign blk_end    = (word_cnt_q == CW'(WORDS_PER_BLOCK - 1));
  assign cnt_next   = blk_end ? '0 : word_cnt_q + 1'b1;
  assign short_last = Msg_in_last && (Msg_in_bytes < BW'(BYTES_PER_WORD));

  always_comb begin
    msg_word = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (!short_last || i < int'(Msg_in_bytes))
        msg_word[8*i +: 8] = Msg_in[8*i +: 8];
      else if (i == int'(Msg_in_bytes))
        msg_word[8*i +: 8] = 8'h01;
      else
        msg_word[8*i +: 8] = 8'h00;
    end
    if (short_last && blk_end)
      msg_word[IN_BUF_SIZE-1 -: 8] = msg_word[IN_BUF_SIZE-1 -: 8] | 8'h80;
  end

  always_comb begin
    pad_word      = '0;
    pad_word[0]   = pad_first_q;
    if (blk_end)
      pad_word[IN_BUF_SIZE-1 -: 8] = pad_word[IN_BUF_SIZE-1 -: 8] | 8'h80;
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    pad_first_d = pad_first_q;
    dout_seen_d = dout_seen_q;
    msg_ready   = 1'b0;
    out_valid   = 1'b0;
    out_word    = '0;
    unique case (state_q)
      S_IDLE, S_MSG: begin
        msg_ready = !Din_buffer_full;
        out_valid = Msg_in_valid;
        out_word  = msg_word;
        if (Msg_in_valid && !Din_buffer_full) begin
          word_cnt_d = cnt_next;
          state_d    = S_MSG;
          if (Msg_in_last) begin
            pad_first_d = !short_last;
            if (short_last && blk_end)
              state_d = S_LAST;
            else
              state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        out_valid = 1'b1;
        out_word  = pad_word;
        if (!Din_buffer_full) begin
          word_cnt_d  = cnt_next;
          pad_first_d = 1'b0;
          if (blk_end)
            state_d = S_LAST;
        end
      end
      S_LAST: begin
        dout_seen_d = 1'b0;
        if (Ready && Din_buffer_full)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // leave only on the falling edge of the digest phase
        if (Dout_buffer_out_valid)
          dout_seen_d = 1'b1;
        else if (dout_seen_q)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      pad_first_q <= 1'b0;
      dout_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      pad_first_q <= pad_first_d;
      dout_seen_q <= dout_seen_d;
    end
  end

  assign Msg_in_ready        = msg_ready && !Reset;
  assign Din_buffer_in_valid = out_valid && !Reset;
  assign Din_buffer_in       = out_word;
  assign Last_block          = (state_q == S_LAST);
  assign Busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_keccak_padder.sv
// Scoreboard bench for keccak_padder.
// Expected stream comes from a byte-level pad10*1 model.
module tb_keccak_padder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [63:0] Msg_in;
  logic        Msg_in_valid;
  logic        Msg_in_last;
  logic [3:0]  Msg_in_bytes;
  logic        Msg_in_ready;
  logic [63:0] Din_buffer_in;
  logic        Din_buffer_in_valid;
  logic        Din_buffer_full;
  logic        Ready;
  logic        Last_block;
  logic        Dout_buffer_out_valid;
  logic        Busy;

  int checks = 0;
  int failures = 0;
  int bp_mode = 2;
  logic [63:0] exp_q[$];

  keccak_padder dut (
    .Clock                 (Clock),
    .Reset                 (Reset),
    .Msg_in                (Msg_in),
    .Msg_in_valid          (Msg_in_valid),
    .Msg_in_last           (Msg_in_last),
    .Msg_in_bytes          (Msg_in_bytes),
    .Msg_in_ready          (Msg_in_ready),
    .Din_buffer_in         (Din_buffer_in),
    .Din_buffer_in_valid   (Din_buffer_in_valid),
    .Din_buffer_full       (Din_buffer_full),
    .Ready                 (Ready),
    .Last_block            (Last_block),
    .Dout_buffer_out_valid (Dout_buffer_out_valid),
    .Busy                  (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // backpressure: 0 random, 1 forced full, 2 forced empty
  initial begin
    Din_buffer_full = 1'b0;
    forever begin
      @(posedge Clock);
      #2;
      if (bp_mode == 0)
        Din_buffer_full = ($urandom_range(0, 99) < 30);
      else
        Din_buffer_full = (bp_mode == 1);
    end
  end

  // monitor: pops expected words on every transfer
  initial begin
    bit stalled = 0;
    bit lb_prev = 0;
    logic [63:0] stall_word = '0;
    logic [63:0] e;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        stalled = 0;
        lb_prev = 0;
      end else begin
        if (stalled) begin
          chk("hold_valid", Din_buffer_in_valid, 1);
          chk("hold_word", Din_buffer_in, stall_word);
        end
        if (Din_buffer_in_valid && !Din_buffer_full) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_word got=%h exp=none", Din_buffer_in);
          end else begin
            e = exp_q.pop_front();
            chk("word", Din_buffer_in, e);
          end
        end
        stalled    = Din_buffer_in_valid && Din_buffer_full;
        stall_word = Din_buffer_in;
        if (Last_block && !lb_prev)
          chk("lb_early_pending", exp_q.size(), 0);
        lb_prev = Last_block;
      end
    end
  end

  task automatic drain_seq();
    bp_mode = 2;
    repeat (2) begin
      @(negedge Clock);
      chk("drain_rdy", Msg_in_ready, 0);
    end
    @(posedge Clock);
    #1 Dout_buffer_out_valid = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      chk("drain_rdy_hi", Msg_in_ready, 0);
    end
    @(posedge Clock);
    #1 Dout_buffer_out_valid = 1'b0;
    @(negedge Clock);
    chk("drain_fall_rdy", Msg_in_ready, 0);
    chk("drain_fall_busy", Busy, 1);
    @(negedge Clock);
    chk("drain_exit_rdy", Msg_in_ready, 1);
    chk("drain_exit_busy", Busy, 0);
  endtask

  task automatic send_msg(input int nw, input int b, input bit drain,
                          input int stop);
    logic [7:0]  m[$];
    logic [7:0]  p[$];
    logic [63:0] dw[$];
    logic [63:0] w;
    int n;
    int cyc;
    bit ok;
    for (int i = 0; i < (nw - 1) * 8 + b; i++)
      m.push_back(8'($urandom));
    for (int k = 0; k < nw; k++) begin
      w = {$urandom, $urandom};
      for (int j = 0; j < 8; j++)
        if (k * 8 + j < m.size()) w[8*j +: 8] = m[k*8 + j];
      dw.push_back(w);
    end
    n = (stop < nw) ? stop : nw;
    if (stop < nw) begin
      for (int k = 0; k < n; k++) exp_q.push_back(dw[k]);
    end else begin
      p = m;
      p.push_back(8'h01);
      while (p.size() % 128 != 0) p.push_back(8'h00);
      p[p.size()-1] = p[p.size()-1] | 8'h80;
      for (int k = 0; k < p.size() / 8; k++) begin
        w = '0;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = p[k*8 + j];
        exp_q.push_back(w);
      end
    end
    for (int k = 0; k < n; k++) begin
      Msg_in       = dw[k];
      Msg_in_valid = 1'b1;
      Msg_in_last  = (k == nw - 1);
      Msg_in_bytes = (k == nw - 1) ? 4'(b) : 4'($urandom_range(0, 8));
      if (k == 0 && drain) begin
        drain_seq();
      end else begin
        cyc = 0;
        ok  = 0;
        while (!ok && cyc < 2000) begin
          @(negedge Clock);
          chk("rdy_mirror", Msg_in_ready, !Din_buffer_full);
          ok = Msg_in_ready;
          cyc++;
        end
        if (!ok) begin
          checks++;
          failures++;
          $display("FAIL ready_timeout got=0 exp=1");
        end
      end
      @(posedge Clock);
      #1 bp_mode = 0;
    end
    Msg_in_valid = 1'b0;
    Msg_in_last  = 1'b0;
  endtask

  task automatic finish_msg();
    int cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
    end while (!Last_block && cyc < 600);
    chk("last_block_rise", Last_block, 1);
    if (!Last_block) return;
    @(posedge Clock);
    #1 Ready = 1'b1;
    bp_mode = 2;
    @(negedge Clock);
    chk("last_hold", Last_block, 1);
    @(posedge Clock);
    #1 bp_mode = 1;
    @(posedge Clock);
    #1 Ready = 1'b0;
    bp_mode = 2;
    @(negedge Clock);
    chk("drain_entry_lb", Last_block, 0);
    chk("drain_entry_busy", Busy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    Msg_in = '0;
    Msg_in_valid = 1'b1;
    Msg_in_last = 1'b0;
    Msg_in_bytes = '0;
    Ready = 1'b0;
    Dout_buffer_out_valid = 1'b0;
    @(negedge Clock);
    chk("rst_ready", Msg_in_ready, 0);
    chk("rst_valid", Din_buffer_in_valid, 0);
    chk("rst_lb", Last_block, 0);
    chk("rst_busy", Busy, 0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    Msg_in_valid = 1'b0;
    bp_mode = 0;

    send_msg(1, 0, 0, 99);
    finish_msg();
    send_msg(1, 3, 1, 99);
    finish_msg();
    send_msg(16, 8, 1, 99);
    finish_msg();
    send_msg(16, 7, 1, 99);
    finish_msg();
    for (int r = 0; r < 6; r++) begin
      send_msg($urandom_range(1, 40), $urandom_range(0, 8), 1, 999);
      finish_msg();
    end

    send_msg(12, 5, 1, 7);
    chk("rst_flush", exp_q.size(), 0);
    Reset = 1'b1;
    Msg_in_valid = 1'b1;
    bp_mode = 2;
    @(negedge Clock);
    chk("midrst_ready", Msg_in_ready, 0);
    chk("midrst_valid", Din_buffer_in_valid, 0);
    chk("midrst_lb", Last_block, 0);
    chk("midrst_busy", Busy, 0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    Msg_in_valid = 1'b0;
    bp_mode = 0;
    send_msg(1, 0, 0, 99);
    finish_msg();
    chk("final_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keccak_padder.md
# keccak_padder

Host-side transmitter feeding `keccak_buffer`. It accepts a byte-granular message stream, applies Keccak pad10*1 padding, and emits `IN_BUF_SIZE`-bit words until each 1024-bit rate block is complete. It obeys `Din_buffer_full` backpressure and raises `Last_block` only after the final padded block has fully transferred. It then holds off new messages until the buffer's digest output phase completes.

## Interface
- `IN_BUF_SIZE`, default `pkg_keccak::IN_BUF_SIZE` (64): word width W. Must divide 1024 and be a multiple of 8.
- `WORDS_PER_BLOCK`, derived as 1024/W (16): words per rate block.
- `BYTES_PER_WORD`, derived as W/8 (8).
- `Clock`  in  1: rising-edge clock.
- `Reset`  in  1: asynchronous, active-high.
- `Msg_in`  in  W: message word. Byte i is in bits [8i+7:8i], and the first message byte is byte 0.
- `Msg_in_valid`  in  1: `Msg_in` is valid.
- `Msg_in_last`  in  1: this word is the final message word.
- `Msg_in_bytes`  in  $clog2(BYTES_PER_WORD+1): valid byte count of the last word, range 0..BYTES_PER_WORD. It is ignored unless `Msg_in_last` is high.
- `Msg_in_ready`  out  1: the padder accepts `Msg_in` this cycle.
- `Din_buffer_in`  out  W: word to the buffer.
- `Din_buffer_in_valid`  out  1: `Din_buffer_in` is valid.
- `Din_buffer_full`  in  1: buffer backpressure.
- `Ready`  in  1: permutation ready, the same net that feeds the buffer.
- `Last_block`  out  1: the final block is loaded in the buffer.
- `Dout_buffer_out_valid`  in  1: the buffer's digest-output valid.
- `Busy`  out  1: high in any state other than IDLE.

## Operation
**Transfer rules**
- A word transfers when `Din_buffer_in_valid` is high and `Din_buffer_full` is low.
- `word_cnt` (0..WORDS_PER_BLOCK-1) increments on each transfer and wraps to 0 after WORDS_PER_BLOCK-1.

**States**
- **IDLE.** `Msg_in_ready` = !`Din_buffer_full`. A valid word moves the FSM to MSG and is processed exactly as in MSG during that same cycle.
- **MSG (pass-through).**
  - Combinational path: `Din_buffer_in_valid` = `Msg_in_valid`, and `Msg_in_ready` = !`Din_buffer_full`.
  - A non-last word passes unmodified.
  - A last word with b < BYTES_PER_WORD bytes is sent as follows:
    - Bytes 0..b-1 carry the message.
    - Byte b = 0x01.
    - Bytes above b = 0x00.
    - If `word_cnt` = WORDS_PER_BLOCK-1, byte BYTES_PER_WORD-1 is ORed with 0x80. When b = BYTES_PER_WORD-1 this gives 0x81.
  - After a short last word transfers, go to LAST if `word_cnt` was WORDS_PER_BLOCK-1; otherwise go to PAD with `pad_first`=0.
  - A full last word (b = BYTES_PER_WORD) passes unmodified, then go to PAD with `pad_first`=1.
- **PAD.** `Msg_in_ready`=0 and `Din_buffer_in_valid`=1. The generated word is:
  - byte 0 = 0x01 if `pad_first`, otherwise 0x00;
  - top byte |= 0x80 if `word_cnt` = WORDS_PER_BLOCK-1.
  - `pad_first` clears on each transfer.
  - On transfer with `word_cnt` = WORDS_PER_BLOCK-1, go to LAST.
  - A full last word at `word_cnt` = WORDS_PER_BLOCK-1 therefore produces a whole extra padding block: first word 0x01, last word 0x80<<(W-8).
- **LAST.** `Last_block`=1 and `Din_buffer_in_valid`=0. When `Ready` && `Din_buffer_full` is sampled high, clear `Last_block` and go to DRAIN.
- **DRAIN.** `Msg_in_ready`=0. Wait for `Dout_buffer_out_valid` to rise, then for it to fall. On the fall, go to IDLE.
- `Last_block` is never asserted before the final word of the final block has transferred. Asserting it earlier would switch the buffer to output mode on a prior block's `Ready`.

## Timing
- Reset values: state=IDLE, `word_cnt`=0, `pad_first`=0, `Last_block`=0, `Busy`=0.
- While `Reset` is asserted, `Msg_in_ready`=0 and `Din_buffer_in_valid`=0.
- Zero-latency pass-through in MSG. There is no internal storage of message words.
- The message path sustains one word per cycle while `Din_buffer_full` is low. PAD sustains the same rate.
- LAST→DRAIN takes 1 cycle after `Ready`&&`Din_buffer_full`. DRAIN→IDLE takes 1 cycle after the `Dout_buffer_out_valid` falling edge.
- Reset mid-message: everything returns to reset values immediately and the partial message is discarded. The buffer must be reset together with the padder.
- `Msg_in_valid` while not ready: the word is held by the host and not consumed. `Msg_in` must remain stable.

## Test plan
- **Empty message.** Apply `Msg_in_last`=1, `Msg_in_bytes`=0 in IDLE. Required words: word0 = 0x01, words1..14 = 0, word15 = 0x8000000000000000. Then `Last_block` rises.
- **3-byte message.** Apply `Msg_in`=0x636261, last, bytes=3. Required: word0 = 0x0000000001636261, zeros after it, top word 0x80<<56, then `Last_block`.
- **Full block, full last word.** Send 16 full words with the 16th marked last. Required: the 16 words pass through, then a padding block 0x01, 0x0 ×14, 0x80<<56. `Last_block` rises only after the 32nd transfer.
- **Short last word at word 15.** Send 15 full words, then word 16 with bytes=7. Required: byte7 = 0x81 and no extra block.
- **Backpressure.** Toggle `Din_buffer_full` randomly during MSG and PAD. Required: no word is lost or duplicated, `Msg_in_ready` mirrors !`Din_buffer_full`, and the PAD word holds stable while full.
- **Drain and reset.**
  - Second message offered during DRAIN: `Msg_in_ready` stays 0 until 1 cycle after `Dout_buffer_out_valid` falls.
  - `Reset` pulsed at word 7: all outputs return to reset values, and the next message starts with `word_cnt`=0.
